// File: rtl/div_pkg.sv
// Shared constants for the multi-cycle divider.
// State encodings are plain 2-bit constants.
package div_pkg;

  localparam int DIV_WIDTH = 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CHECK  = 2'd1;
  localparam logic [1:0] ITER   = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration.
// Purely combinational; the sequencer registers the outputs.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_nx,
  output logic [WIDTH-1:0] q_nx
);

  logic [WIDTH:0] sh;
  logic [WIDTH:0] dx;

  // r < d always holds, so the shifted value fits in WIDTH+1 bits
  always_comb begin
    sh   = {r[WIDTH-1:0], q[WIDTH-1]};
    dx   = {1'b0, d};
    r_nx = sh;
    q_nx = {q[WIDTH-2:0], 1'b0};
    if (sh >= dx) begin
      r_nx    = sh - dx;
      q_nx[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle unsigned restoring divider.
// One quotient bit per clock with busy/done/error handshake.
module div_sequencer
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   r_nx;
  logic [WIDTH-1:0] q_nx;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r    (r),
    .q    (q),
    .d    (d),
    .r_nx (r_nx),
    .q_nx (q_nx)
  );

  assign busy = (state == CHECK) || (state == ITER);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      r         <= '0;
      q         <= '0;
      d         <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        error     <= 1'b0;
        quotient  <= '0;
        remainder <= '0;
      end else begin
        case (state)
          // FINISH accepts too, so a new start can overlap the done pulse
          IDLE, FINISH: begin
            state <= IDLE;
            if (start) begin
              state <= CHECK;
              q     <= dividend;
              d     <= divisor;
              r     <= '0;
              error <= 1'b0;
            end
          end
          CHECK: begin
            if (d == '0) begin
              error     <= 1'b1;
              quotient  <= '0;
              remainder <= '0;
              done      <= 1'b1;
              state     <= FINISH;
            end else begin
              cnt   <= CW'(WIDTH - 1);
              state <= ITER;
            end
          end
          ITER: begin
            r   <= r_nx;
            q   <= q_nx;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
              quotient  <= q_nx;
              remainder <= r_nx[WIDTH-1:0];
              done      <= 1'b1;
              state     <= FINISH;
            end
          end
        endcase
      end
    end
  end

endmodule
